// File: rtl/sm_pkg.sv
// Shared types and constants for the stepper-motor phase sequencer.
package sm_pkg;

  localparam int POS_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SETTLE,
    DONE
  } sm_state_t;

  // Coil drive {A,B,C,D} per phase index. Even entries are one-phase-on,
  // odd entries are two-phase-on, so full-step walks odd indices only.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001,  // 7
    4'b0001,  // 6
    4'b0011,  // 5
    4'b0010,  // 4
    4'b0110,  // 3
    4'b0100,  // 2
    4'b1100,  // 1
    4'b1000   // 0
  };

endpackage

// File: rtl/sm_step_edge.sv
// Rising-edge detector for the step strobe from the step-rate generator.
module sm_step_edge (
  input  logic clk,
  input  logic rst,
  input  logic drv_step,
  output logic step_rise
);

  logic drv_step_q;

  // Remember last cycle's strobe level so a held-high strobe counts once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drv_step_q <= 1'b0;
    end else begin
      drv_step_q <= drv_step;
    end
  end

  assign step_rise = drv_step & ~drv_step_q;

endmodule

// File: rtl/sm_phase_sequencer.sv
// Stepper-motor coil sequencer: runs a move of N steps in full- or half-step
// mode, tracks signed position, dwells for settling, then pulses done.
module sm_phase_sequencer
  import sm_pkg::*;
#(
  parameter int POS_W      = POS_W_DEF,
  parameter int SETTLE_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drv_step,
  input  logic             move_start,
  input  logic [POS_W-1:0] target_steps,
  input  logic             dir,
  input  logic             half_mode,
  input  logic             hold_en,
  input  logic             abort,
  output logic             drv_enable_SM,
  output logic [3:0]       coils,
  output logic [POS_W-1:0] position,
  output logic [POS_W-1:0] steps_left,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  sm_state_t        state, state_nxt;
  logic [2:0]       idx, idx_nxt, idx_delta;
  logic             dir_q, dir_nxt;
  logic             half_q, half_nxt;
  logic [CNT_W-1:0] settle_cnt, cnt_nxt;
  logic [POS_W-1:0] pos_nxt, left_nxt;
  logic             step_rise, step_acc;

  sm_step_edge u_step_edge (
    .clk       (clk),
    .rst       (rst),
    .drv_step  (drv_step),
    .step_rise (step_rise)
  );

  // Next-state and counter logic; abort always wins over a same-cycle step.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dir_nxt   = dir_q;
    half_nxt  = half_q;
    cnt_nxt   = settle_cnt;
    pos_nxt   = position;
    left_nxt  = steps_left;
    idx_delta = half_q ? 3'd1 : 3'd2;
    step_acc  = step_rise & (state == RUN) & ~abort;
    case (state)
      IDLE: begin
        if (move_start && !abort) begin
          dir_nxt  = dir;
          half_nxt = half_mode;
          left_nxt = target_steps;
          cnt_nxt  = '0;
          if (!half_mode) begin
            idx_nxt[0] = 1'b1;
          end
          state_nxt = (target_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (step_acc) begin
          idx_nxt  = dir_q ? (idx + idx_delta) : (idx - idx_delta);
          pos_nxt  = dir_q ? (position + POS_W'(1)) : (position - POS_W'(1));
          left_nxt = steps_left - POS_W'(1);
          if (steps_left == POS_W'(1)) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = settle_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Register the FSM, counters and all outputs (coils follow the new index).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      idx           <= 3'd0;
      dir_q         <= 1'b0;
      half_q        <= 1'b0;
      settle_cnt    <= '0;
      position      <= '0;
      steps_left    <= '0;
      coils         <= 4'b0000;
      drv_enable_SM <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      dir_q         <= dir_nxt;
      half_q        <= half_nxt;
      settle_cnt    <= cnt_nxt;
      position      <= pos_nxt;
      steps_left    <= left_nxt;
      coils         <= (state_nxt == IDLE && !hold_en) ? 4'b0000 : PHASE_TABLE[idx_nxt];
      drv_enable_SM <= (state_nxt == RUN);
      busy          <= (state_nxt == RUN) || (state_nxt == SETTLE);
      done          <= (state == DONE);
      aborted       <= abort && ((state == RUN) || (state == SETTLE));
    end
  end

endmodule
